// File: rtl/shaped_pulse_peak_detector_if.sv
// Event read-out bundle of the shaped pulse peak detector.
// Ports: out_valid/out_ready handshake plus the head event fields
//   (out_amp, out_ts, out_width, out_flags); master drives, slave consumes.
interface shaped_pulse_peak_detector_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_amp;
  logic [TS_W-1:0]   out_ts;
  logic [7:0]        out_width;
  logic [1:0]        out_flags;

  modport master (
    output out_valid, out_amp, out_ts, out_width, out_flags,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_amp, out_ts, out_width, out_flags,
    output out_ready
  );
endinterface

// File: rtl/shaped_pulse_peak_detector.sv
// Shaped pulse peak detector: thresholds the trapezoidal filter output,
// measures peak amplitude / peak timestamp / width of each pulse and queues
// one event record per pulse.
// Ports: clk, reset (sync, active-high), in_data, threshold (signed samples),
//   evt (event read-out interface, master), drop_cnt (events lost to full FIFO).

// Generic synchronous FIFO, first-word-fall-through, head read straight from storage.
// Latency: a written word is visible at rd_dat/rd_vld on the cycle after the write.
// Backpressure: wr_rdy drops when full unless a read frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  input  logic             rd_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign rd_vld = (count != '0);
  assign do_rd  = rd_vld && rd_rdy;
  // A read in the same cycle frees the slot the write needs.
  assign wr_rdy = (count != FULL_CNT) || do_rd;
  assign do_wr  = wr_vld && wr_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Cleared so the head fields read zero out of reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Pulse detector FSM plus event queue for the shaped filter stream.
// Latency: event is visible at the interface 1 cycle after the terminating sample.
// Backpressure: input is never stalled; events arriving at a full queue are counted and dropped.
module shaped_pulse_peak_detector #(
  parameter int DATA_W     = 16,
  parameter int TS_W       = 32,
  parameter int MAX_WIDTH  = 64,
  parameter int DEADTIME   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            in_data,
  input  logic [DATA_W-1:0]            threshold,
  shaped_pulse_peak_detector_if.master evt,
  output logic [15:0]                  drop_cnt
);
  localparam int DCW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEADTIME - 1);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_LOW, DEAD} state_t;

  typedef struct packed {
    logic [1:0]        flags;   // bit1 overflow, bit0 pileup
    logic [7:0]        width;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] amp;
  } event_t;

  state_t                    state_q, state_d;
  logic [TS_W-1:0]           ts_q;
  logic signed [DATA_W-1:0]  amp_q, amp_d;
  logic signed [DATA_W-1:0]  prev_q, prev_d;
  logic [TS_W-1:0]           peak_ts_q, peak_ts_d;
  logic [7:0]                width_q, width_d;
  logic                      pileup_q, pileup_d;
  logic                      falling_q, falling_d;
  logic [DCW-1:0]            dead_q, dead_d;

  logic signed [DATA_W-1:0]  sample;
  logic signed [DATA_W-1:0]  thr;
  logic                      above;
  logic                      ev_vld;
  logic                      ev_ovf;
  event_t                    ev_dat;
  logic                      ev_rdy;
  event_t                    head_dat;
  logic                      head_vld;

  assign sample = $signed(in_data);
  assign thr    = $signed(threshold);
  assign above  = (sample > thr);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ts_q      <= '0;
      amp_q     <= '0;
      prev_q    <= '0;
      peak_ts_q <= '0;
      width_q   <= '0;
      pileup_q  <= 1'b0;
      falling_q <= 1'b0;
      dead_q    <= '0;
    end else begin
      state_q   <= state_d;
      ts_q      <= ts_q + 1'b1;
      amp_q     <= amp_d;
      prev_q    <= prev_d;
      peak_ts_q <= peak_ts_d;
      width_q   <= width_d;
      pileup_q  <= pileup_d;
      falling_q <= falling_d;
      dead_q    <= dead_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    amp_d     = amp_q;
    prev_d    = prev_q;
    peak_ts_d = peak_ts_q;
    width_d   = width_q;
    pileup_d  = pileup_q;
    falling_d = falling_q;
    dead_d    = dead_q;
    ev_vld    = 1'b0;
    ev_ovf    = 1'b0;

    case (state_q)
      IDLE: begin
        if (above) begin
          state_d   = PULSE;
          amp_d     = sample;
          prev_d    = sample;
          peak_ts_d = ts_q;
          width_d   = 8'd1;
          pileup_d  = 1'b0;
          falling_d = 1'b0;
        end
      end

      PULSE: begin
        if (above) begin
          width_d = (width_q == 8'hFF) ? width_q : width_q + 8'd1;
          // Strict compare keeps the first sample of a flat top as the peak.
          if (sample > amp_q) begin
            amp_d     = sample;
            peak_ts_d = ts_q;
          end
          if (sample < prev_q) falling_d = 1'b1;
          // A rise after the pulse has started falling means a second pulse rode in.
          if (falling_q && (sample > prev_q)) pileup_d = 1'b1;
          prev_d = sample;
          if ({24'd0, width_d} == 32'(MAX_WIDTH)) begin
            ev_vld  = 1'b1;
            ev_ovf  = 1'b1;
            state_d = WAIT_LOW;
          end
        end else begin
          // Terminating sample is not counted in the width.
          ev_vld  = 1'b1;
          state_d = DEAD;
          dead_d  = '0;
        end
      end

      WAIT_LOW: begin
        if (!above) begin
          state_d = DEAD;
          dead_d  = '0;
        end
      end

      DEAD: begin
        if (dead_q == DEAD_LAST) state_d = IDLE;
        else                     dead_d  = dead_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // Built from the next-state values so an overflow push includes the final sample.
  always_comb begin
    ev_dat       = '0;
    ev_dat.amp   = amp_d;
    ev_dat.ts    = peak_ts_d;
    ev_dat.width = width_d;
    ev_dat.flags = {ev_ovf, pileup_d};
  end

  sync_fifo #(
    .WIDTH ($bits(event_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_vld (ev_vld),
    .wr_dat (ev_dat),
    .wr_rdy (ev_rdy),
    .rd_vld (head_vld),
    .rd_dat (head_dat),
    .rd_rdy (evt.out_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (ev_vld && !ev_rdy && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign evt.out_valid = head_vld;
  assign evt.out_amp   = head_dat.amp;
  assign evt.out_ts    = head_dat.ts;
  assign evt.out_width = head_dat.width;
  assign evt.out_flags = head_dat.flags;
endmodule

// File: tb/tb_shaped_pulse_peak_detector.sv
// Directed bench for shaped_pulse_peak_detector: one task per scenario,
// hand-computed expected event records, summary line at the end.
module tb_shaped_pulse_peak_detector;
  logic        clk;
  logic        reset;
  logic [15:0] in_data;
  logic [15:0] threshold;
  logic [15:0] drop_cnt;
  int          tests_run;
  int          tests_failed;

  shaped_pulse_peak_detector_if #(.DATA_W(16), .TS_W(32)) evt ();

  shaped_pulse_peak_detector #(
    .DATA_W(16), .TS_W(32), .MAX_WIDTH(64), .DEADTIME(8), .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .threshold (threshold),
    .evt       (evt),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one sample for one clock; returns 1 time unit after the edge.
  task automatic step(input logic [15:0] s);
    in_data = s;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  // After this returns, the sample presented next has timestamp 0.
  task automatic do_reset();
    reset   = 1'b1;
    in_data = 16'd0;
    evt.out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pop_one();
    evt.out_ready = 1'b1;
    step(16'd0);
    evt.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (evt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %0b want 0", evt.out_valid); end
    tests_run++; if (evt.out_amp !== 16'd0) begin tests_failed++; $display("FAIL reset_amp: got %0d want 0", evt.out_amp); end
    tests_run++; if (evt.out_ts !== 32'd0) begin tests_failed++; $display("FAIL reset_ts: got %0d want 0", evt.out_ts); end
    tests_run++; if (evt.out_width !== 8'd0) begin tests_failed++; $display("FAIL reset_width: got %0d want 0", evt.out_width); end
    tests_run++; if (evt.out_flags !== 2'b00) begin tests_failed++; $display("FAIL reset_flags: got %b want 00", evt.out_flags); end
    tests_run++; if (drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_basic_pulse();
    do_reset();
    steps(16'd0, 10);                       // ts 0..9
    step(16'd0); step(16'd50); step(16'd150);
    step(16'd300); step(16'd250); step(16'd120); // ts 10..15
    tests_run++; if (evt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %0b want 0", evt.out_valid); end
    step(16'd90);                           // ts 16, terminates
    tests_run++; if (evt.out_valid !== 1'b1) begin tests_failed++; $display("FAIL basic_valid: got %0b want 1", evt.out_valid); end
    tests_run++; if (evt.out_amp !== 16'd300) begin tests_failed++; $display("FAIL basic_amp: got %0d want 300", evt.out_amp); end
    tests_run++; if (evt.out_ts !== 32'd13) begin tests_failed++; $display("FAIL basic_ts: got %0d want 13", evt.out_ts); end
    tests_run++; if (evt.out_width !== 8'd4) begin tests_failed++; $display("FAIL basic_width: got %0d want 4", evt.out_width); end
    tests_run++; if (evt.out_flags !== 2'b00) begin tests_failed++; $display("FAIL basic_flags: got %b want 00", evt.out_flags); end
    pop_one();
    tests_run++; if (evt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_after_pop: got %0b want 0", evt.out_valid); end
  endtask

  task automatic test_pileup();
    do_reset();
    step(16'd0); step(16'd200); step(16'd400); step(16'd300);
    step(16'd350); step(16'd200); step(16'd50);  // ts 0..6
    tests_run++; if (evt.out_valid !== 1'b1) begin tests_failed++; $display("FAIL pileup_valid: got %0b want 1", evt.out_valid); end
    tests_run++; if (evt.out_amp !== 16'd400) begin tests_failed++; $display("FAIL pileup_amp: got %0d want 400", evt.out_amp); end
    tests_run++; if (evt.out_ts !== 32'd2) begin tests_failed++; $display("FAIL pileup_ts: got %0d want 2", evt.out_ts); end
    tests_run++; if (evt.out_width !== 8'd5) begin tests_failed++; $display("FAIL pileup_width: got %0d want 5", evt.out_width); end
    tests_run++; if (evt.out_flags !== 2'b01) begin tests_failed++; $display("FAIL pileup_flags: got %b want 01", evt.out_flags); end
    pop_one();
  endtask

  task automatic test_overflow();
    do_reset();
    steps(16'd0, 5);                        // ts 0..4
    steps(16'd500, 64);                     // ts 5..68, 64th sample overflows
    tests_run++; if (evt.out_valid !== 1'b1) begin tests_failed++; $display("FAIL ovf_valid: got %0b want 1", evt.out_valid); end
    tests_run++; if (evt.out_amp !== 16'd500) begin tests_failed++; $display("FAIL ovf_amp: got %0d want 500", evt.out_amp); end
    tests_run++; if (evt.out_ts !== 32'd5) begin tests_failed++; $display("FAIL ovf_ts: got %0d want 5", evt.out_ts); end
    tests_run++; if (evt.out_width !== 8'd64) begin tests_failed++; $display("FAIL ovf_width: got %0d want 64", evt.out_width); end
    tests_run++; if (evt.out_flags !== 2'b10) begin tests_failed++; $display("FAIL ovf_flags: got %b want 10", evt.out_flags); end
    evt.out_ready = 1'b1;
    step(16'd500);                          // ts 69, pops the event
    evt.out_ready = 1'b0;
    steps(16'd500, 5);                      // ts 70..74
    tests_run++; if (evt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_wait_low: got %0b want 0", evt.out_valid); end
    step(16'd0);                            // ts 75 ends the over-length pulse
    steps(16'd200, 8);                      // ts 76..83 dead
    tests_run++; if (evt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL ovf_dead: got %0b want 0", evt.out_valid); end
    step(16'd200);                          // ts 84 triggers
    step(16'd0);                            // ts 85 terminates
    tests_run++; if (evt.out_valid !== 1'b1) begin tests_failed++; $display("FAIL ovf_next_valid: got %0b want 1", evt.out_valid); end
    tests_run++; if (evt.out_ts !== 32'd84) begin tests_failed++; $display("FAIL ovf_next_ts: got %0d want 84", evt.out_ts); end
    tests_run++; if (evt.out_width !== 8'd1) begin tests_failed++; $display("FAIL ovf_next_width: got %0d want 1", evt.out_width); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_amp;
    do_reset();
    for (int i = 0; i < 6; i++) begin       // pulse i at ts 20*i
      step(16'd200 + 16'(10 * i));
      steps(16'd0, 19);
    end
    tests_run++; if (drop_cnt !== 16'd2) begin tests_failed++; $display("FAIL bp_drop: got %0d want 2", drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      exp_amp = 16'd200 + 16'(10 * i);
      tests_run++; if (evt.out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid%0d: got %0b want 1", i, evt.out_valid); end
      tests_run++; if (evt.out_amp !== exp_amp) begin tests_failed++; $display("FAIL bp_amp%0d: got %0d want %0d", i, evt.out_amp, exp_amp); end
      tests_run++; if (evt.out_ts !== 32'(20 * i)) begin tests_failed++; $display("FAIL bp_ts%0d: got %0d want %0d", i, evt.out_ts, 20 * i); end
      evt.out_ready = 1'b1;
      step(16'd0);
    end
    evt.out_ready = 1'b0;
    tests_run++; if (evt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drained: got %0b want 0", evt.out_valid); end
  endtask

  task automatic test_deadtime();
    do_reset();
    steps(16'd0, 98);                       // ts 0..97
    step(16'd200); step(16'd200);           // ts 98, 99
    step(16'd0);                            // ts 100 terminates
    tests_run++; if (evt.out_ts !== 32'd98) begin tests_failed++; $display("FAIL dead_first_ts: got %0d want 98", evt.out_ts); end
    tests_run++; if (evt.out_width !== 8'd2) begin tests_failed++; $display("FAIL dead_first_width: got %0d want 2", evt.out_width); end
    pop_one();                              // ts 101
    step(16'd0);                            // ts 102
    step(16'd300);                          // ts 103 ignored
    steps(16'd0, 4);                        // ts 104..107
    step(16'd300);                          // ts 108 ignored, last dead cycle
    tests_run++; if (evt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL dead_ignored: got %0b want 0", evt.out_valid); end
    step(16'd250);                          // ts 109 triggers
    step(16'd0);                            // ts 110 terminates
    tests_run++; if (evt.out_valid !== 1'b1) begin tests_failed++; $display("FAIL dead_retrigger_valid: got %0b want 1", evt.out_valid); end
    tests_run++; if (evt.out_amp !== 16'd250) begin tests_failed++; $display("FAIL dead_retrigger_amp: got %0d want 250", evt.out_amp); end
    tests_run++; if (evt.out_ts !== 32'd109) begin tests_failed++; $display("FAIL dead_retrigger_ts: got %0d want 109", evt.out_ts); end
    pop_one();
  endtask

  task automatic test_reset_midpulse();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      step(16'd200);
      steps(16'd0, 19);
    end
    tests_run++; if (evt.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_valid: got %0b want 1", evt.out_valid); end
    step(16'd500); step(16'd500);           // pulse in progress
    reset   = 1'b1;
    in_data = 16'd500;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    in_data = 16'd0;
    tests_run++; if (evt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %0b want 0", evt.out_valid); end
    tests_run++; if (evt.out_amp !== 16'd0) begin tests_failed++; $display("FAIL rst_amp: got %0d want 0", evt.out_amp); end
    tests_run++; if (drop_cnt !== 16'd0) begin tests_failed++; $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
    step(16'd0); step(16'd0);               // ts 0, 1
    tests_run++; if (evt.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_no_stale_event: got %0b want 0", evt.out_valid); end
    step(16'd200);                          // ts 2
    step(16'd0);                            // ts 3
    tests_run++; if (evt.out_valid !== 1'b1) begin tests_failed++; $display("FAIL rst_new_valid: got %0b want 1", evt.out_valid); end
    tests_run++; if (evt.out_ts !== 32'd2) begin tests_failed++; $display("FAIL rst_new_ts: got %0d want 2", evt.out_ts); end
    pop_one();
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    in_data       = 16'd0;
    threshold     = 16'd100;
    evt.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_pulse();
    test_pileup();
    test_overflow();
    test_back_to_back();
    test_deadtime();
    test_reset_midpulse();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/shaped_pulse_peak_detector.md
Name: shaped_pulse_peak_detector

Overview:
- Sits directly downstream of the trapezoidal shaping filter and consumes its output_data stream, one signed sample per clk.
- Detects each shaped pulse against a runtime threshold and measures its peak amplitude, peak timestamp and width above threshold.
- Flags pile-up and over-length pulses.
- Queues one event record per pulse in a small FIFO, read out with a valid/ready handshake.

Parameters:
- DATA_W, 16, sample width; equals the filter's SIZE_FILTER_DATA.
- TS_W, 32, timestamp counter width.
- MAX_WIDTH, 64, maximum samples above threshold before the pulse is declared overflow.
- DEADTIME, 8, cycles ignored after each pulse ends.
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  signed shaped sample from the filter; valid every cycle.
- threshold  input  DATA_W  signed trigger level; sampled every cycle.
- out_valid  output  1  event available at FIFO head.
- out_ready  input  1  consumer accepts the head event.
- out_amp  output  DATA_W  signed peak value.
- out_ts  output  TS_W  timestamp of the peak sample.
- out_width  output  8  samples strictly above threshold, saturating at 255.
- out_flags  output  2  bit0 = pileup, bit1 = overflow.
- drop_cnt  output  16  saturating count of events lost to a full FIFO.

Behaviour:
- Reset values: ts counter = 0, state = IDLE, FIFO empty, out_valid = 0, out_amp/out_ts/out_width/out_flags = 0, drop_cnt = 0. Reset also discards any pulse in progress.
- Timestamp: free-running TS_W counter, +1 per clk, wraps modulo 2^TS_W. A sample's timestamp is the counter value in the cycle that sample is presented.
- "Above threshold" means signed in_data > threshold. Equality counts as not above.
- IDLE: a sample above threshold goes to PULSE.
  - amp = sample, peak_ts = ts, width = 1, pileup = 0, falling = 0.
- PULSE, each cycle with sample above threshold:
  - width += 1, saturating at 255.
  - If sample > amp (strictly), update amp and peak_ts. On ties the first occurrence is kept.
  - If sample < prev sample, set falling.
  - If falling and sample > prev sample, set pileup (sticky).
  - If width reaches MAX_WIDTH on this sample, set overflow, push event, go to WAIT_LOW.
- PULSE, sample not above threshold: push event (overflow = 0), go to DEAD. The terminating sample is not counted in width.
- WAIT_LOW: stay until a sample is not above threshold, then go to DEAD. No events are generated.
- DEAD: ignore input for exactly DEADTIME cycles, then go to IDLE. The first sample that can trigger is the (DEADTIME+1)th after the terminating sample.
- Push: event is written on the clk edge that sees the terminating (or MAX_WIDTH-th) sample. out_valid rises on the following cycle; latency is 1 cycle after that sample.
- FIFO:
  - First-word-fall-through; outputs are registered from the head entry.
  - out_valid = not empty.
  - Pop on out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
- FIFO full with no pop in the same cycle: the event is dropped and drop_cnt increments, saturating at 0xFFFF.
- FIFO full with a simultaneous pop: the push is accepted and there is no drop.
- Empty FIFO with a simultaneous push: no bypass; out_valid rises next cycle.
- Events leave in arrival order.
- A threshold change mid-pulse takes effect on the next sample compare.

Test Plan:
1. threshold = 100, samples 0,50,150,300,250,120,90 at ts 10..16 -> one event: amp = 300, ts = 13, width = 4, flags = 00; out_valid high from the cycle after ts 16.
2. Samples 0,200,400,300,350,200,50 -> amp = 400, width = 5, flags = 01 (pileup). The 350 does not update amp.
3. Constant 500 for 70 samples starting ts = 5 -> one event: amp = 500, ts = 5 (first of ties), width = 64, flags = 10. No further event until the input drops ≤ 100, then 8 dead cycles elapse.
4. out_ready = 0, six isolated pulses spaced 20 cycles apart -> 4 events held, drop_cnt = 2. With out_ready = 1 afterwards, the 4 events drain in order, one per cycle, and out_valid falls after the 4th.
5. Pulse ending at ts = 100 (sample ≤ 100), then a crossing at ts = 103 -> ignored. A crossing at ts = 109 -> triggers a new pulse.
6. reset asserted for one cycle during PULSE with 2 events queued -> FIFO empty, out_valid = 0, drop_cnt = 0, ts restarts at 0, no event for the interrupted pulse.
